// File: rtl/hyper_titan_pkg.sv
// Shared UART constants: arbiter sizing, register offsets and the arbiter state type.
package hyper_titan_pkg;

  localparam int UART_NUM_REQ     = 4;
  localparam int UART_GNT_DEPTH   = 4;
  localparam int UART_GNT_TIMEOUT = 65536;

  localparam logic [11:0] UART_REQ_ID_PUSH = 12'h004;
  localparam logic [11:0] UART_GNT_ID_PEEK = 12'h008;
  localparam logic [11:0] UART_GNT_ID_POP  = 12'h00C;

  // Bit positions inside err_o
  localparam int ERR_PUSH    = 0;
  localparam int ERR_POP     = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/uart_id_fifo.sv
// Circular buffer of requester IDs; the arbiter guarantees no push on full and no pop on empty.
module uart_id_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = 2
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          push_i,
  input  logic [IW-1:0] push_id_i,
  input  logic          pop_i,
  output logic [IW-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;

  // Explicit wrap so non-power-of-two depths still cycle through DEPTH slots
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_id_i;
        wr_q        <= bump(wr_q);
      end
      if (pop_i) rd_q <= bump(rd_q);
    end
  end

  assign head_o = mem_q[rd_q];

endmodule

// File: rtl/uart_access_arbiter.sv
// FIFO-ordered grant arbiter for shared UART access: bitmap, occupancy, FSM and hold timeout.
// All outputs come from registers; pops are applied before pushes within a cycle.
module uart_access_arbiter
  import hyper_titan_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ,
  parameter int DEPTH   = UART_GNT_DEPTH,
  parameter int TIMEOUT = UART_GNT_TIMEOUT,
  localparam int IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int HW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic               clk_i,
  input  logic               arst_ni,
  input  logic               push_i,
  input  logic [IW-1:0]      push_id_i,
  input  logic               pop_i,
  input  logic [IW-1:0]      pop_id_i,
  input  logic               activity_i,
  output logic               gnt_valid_o,
  output logic [IW-1:0]      gnt_id_o,
  output logic [NUM_REQ-1:0] queued_o,
  output logic [CW-1:0]      count_o,
  output logic [2:0]         err_o
);

  localparam logic [HW-1:0] HOLD_MAX = HW'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

  arb_state_e         state_q;
  logic [CW-1:0]      count_q;
  logic [NUM_REQ-1:0] queued_q;
  logic [HW-1:0]      hold_q;
  logic [2:0]         err_q;
  logic [IW-1:0]      head;

  logic               pop_ok;
  logic               timeout_hit;
  logic               deq;
  logic               push_ok;
  logic [CW-1:0]      cnt_ap;
  logic [CW-1:0]      cnt_nxt;
  logic [NUM_REQ-1:0] q_ap;
  logic [NUM_REQ-1:0] q_nxt;

  // Activity in the deadline cycle counts as use and cancels the forced pop
  always_comb begin
    pop_ok      = pop_i && (state_q == ARB_GRANTED) && (pop_id_i == head);
    timeout_hit = (TIMEOUT != 0) && (state_q == ARB_GRANTED) &&
                  (hold_q == HOLD_MAX) && !activity_i;
    deq         = pop_ok || timeout_hit;

    cnt_ap = count_q - CW'(deq);
    q_ap   = queued_q;
    if (deq) q_ap[head] = 1'b0;

    push_ok = push_i && (int'(push_id_i) < NUM_REQ) && !q_ap[push_id_i] &&
              (int'(cnt_ap) < DEPTH);

    cnt_nxt = cnt_ap + CW'(push_ok);
    q_nxt   = q_ap;
    if (push_ok) q_nxt[push_id_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= ARB_IDLE;
      count_q  <= '0;
      queued_q <= '0;
      hold_q   <= '0;
      err_q    <= '0;
    end else begin
      case (state_q)
        ARB_IDLE:    if (push_ok) state_q <= ARB_GRANTED;
        ARB_GRANTED: if (cnt_nxt == '0) state_q <= ARB_IDLE;
        default:     state_q <= ARB_IDLE;
      endcase

      count_q  <= cnt_nxt;
      queued_q <= q_nxt;

      if (state_q == ARB_IDLE || deq || activity_i) hold_q <= '0;
      else                                          hold_q <= hold_q + HW'(1);

      err_q[ERR_TIMEOUT] <= timeout_hit && !pop_ok;
      err_q[ERR_POP]     <= pop_i && !pop_ok;
      err_q[ERR_PUSH]    <= push_i && !push_ok;
    end
  end

  uart_id_fifo #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .push_i    (push_ok),
    .push_id_i (push_id_i),
    .pop_i     (deq),
    .head_o    (head)
  );

  assign gnt_valid_o = (state_q == ARB_GRANTED);
  assign gnt_id_o    = gnt_valid_o ? head : '0;
  assign queued_o    = queued_q;
  assign count_o     = count_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Directed bench: each stimulus cycle queues the hand-computed post-edge outputs; a monitor checks them.
module tb_uart_access_arbiter;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       push = 1'b0;
  logic [1:0] push_id = '0;
  logic       pop = 1'b0;
  logic [1:0] pop_id = '0;
  logic       act = 1'b0;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic [3:0] queued;
  logic [2:0] count;
  logic [2:0] err;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  typedef struct packed {
    int         tag;
    logic       vld;
    logic [1:0] id;
    logic [3:0] q;
    logic [2:0] cnt;
    logic [2:0] err;
  } exp_t;

  exp_t expq[$];

  uart_access_arbiter #(
    .NUM_REQ (4),
    .DEPTH   (4),
    .TIMEOUT (16)
  ) dut (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .push_i      (push),
    .push_id_i   (push_id),
    .pop_i       (pop),
    .pop_id_i    (pop_id),
    .activity_i  (act),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id),
    .queued_o    (queued),
    .count_o     (count),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, tag, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next rising edge
  task automatic step(input logic ps, input logic [1:0] pid, input logic pp,
                      input logic [1:0] ppid, input logic a, input logic v,
                      input logic [1:0] id, input logic [3:0] q,
                      input logic [2:0] c, input logic [2:0] e);
    @(negedge clk);
    push = ps; push_id = pid; pop = pp; pop_id = ppid; act = a;
    step_no++;
    expq.push_back('{tag: step_no, vld: v, id: id, q: q, cnt: c, err: e});
  endtask

  task automatic check_zero(input string name);
    check({name, "_vld"}, -1, 32'(gnt_valid), 32'd0);
    check({name, "_id"},  -1, 32'(gnt_id),    32'd0);
    check({name, "_q"},   -1, 32'(queued),    32'd0);
    check({name, "_cnt"}, -1, 32'(count),     32'd0);
    check({name, "_err"}, -1, 32'(err),       32'd0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        check("gnt_valid", x.tag, 32'(gnt_valid), 32'(x.vld));
        check("gnt_id",    x.tag, 32'(gnt_id),    32'(x.id));
        check("queued",    x.tag, 32'(queued),    32'(x.q));
        check("count",     x.tag, 32'(count),     32'(x.cnt));
        check("err",       x.tag, 32'(err),       32'(x.err));
      end
    end
  end

  initial begin : stimulus
    #3;
    check_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // FIFO order and head update after a pop
    step(1, 2'd2, 0, 2'd0, 1, 1, 2'd2, 4'b0100, 3'd1, 3'b000);
    step(1, 2'd0, 0, 2'd0, 1, 1, 2'd2, 4'b0101, 3'd2, 3'b000);
    step(1, 2'd3, 0, 2'd0, 1, 1, 2'd2, 4'b1101, 3'd3, 3'b000);
    step(0, 2'd0, 1, 2'd2, 1, 1, 2'd0, 4'b1001, 3'd2, 3'b000);
    step(0, 2'd0, 1, 2'd0, 1, 1, 2'd3, 4'b1000, 3'd1, 3'b000);
    step(0, 2'd0, 1, 2'd3, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    // Duplicate push rejected
    step(1, 2'd1, 0, 2'd0, 1, 1, 2'd1, 4'b0010, 3'd1, 3'b000);
    step(1, 2'd1, 0, 2'd0, 1, 1, 2'd1, 4'b0010, 3'd1, 3'b001);
    step(0, 2'd0, 0, 2'd0, 1, 1, 2'd1, 4'b0010, 3'd1, 3'b000);

    // Pop by non-holder, then pop on empty
    step(0, 2'd0, 1, 2'd3, 1, 1, 2'd1, 4'b0010, 3'd1, 3'b010);
    step(0, 2'd0, 1, 2'd1, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);
    step(0, 2'd0, 1, 2'd0, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b010);
    step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    // Fill, reject on full, same-cycle pop+push of head, drain across pointer wrap
    step(1, 2'd0, 0, 2'd0, 1, 1, 2'd0, 4'b0001, 3'd1, 3'b000);
    step(1, 2'd1, 0, 2'd0, 1, 1, 2'd0, 4'b0011, 3'd2, 3'b000);
    step(1, 2'd2, 0, 2'd0, 1, 1, 2'd0, 4'b0111, 3'd3, 3'b000);
    step(1, 2'd3, 0, 2'd0, 1, 1, 2'd0, 4'b1111, 3'd4, 3'b000);
    step(1, 2'd0, 0, 2'd0, 1, 1, 2'd0, 4'b1111, 3'd4, 3'b001);
    step(1, 2'd0, 1, 2'd0, 1, 1, 2'd1, 4'b1111, 3'd4, 3'b000);
    step(0, 2'd0, 1, 2'd1, 1, 1, 2'd2, 4'b1101, 3'd3, 3'b000);
    step(0, 2'd0, 1, 2'd2, 1, 1, 2'd3, 4'b1001, 3'd2, 3'b000);
    step(0, 2'd0, 1, 2'd3, 1, 1, 2'd0, 4'b0001, 3'd1, 3'b000);
    step(0, 2'd0, 1, 2'd0, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    // Idle holder: counter reaches 15 in the 16th granted cycle and forces the pop
    step(1, 2'd2, 0, 2'd0, 0, 1, 2'd2, 4'b0100, 3'd1, 3'b000);
    for (int i = 0; i < 15; i++)
      step(0, 2'd0, 0, 2'd0, 0, 1, 2'd2, 4'b0100, 3'd1, 3'b000);
    step(0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 3'd0, 3'b100);
    step(0, 2'd0, 0, 2'd0, 0, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    // User pop landing on the deadline cycle is a single pop with no timeout pulse
    step(1, 2'd3, 0, 2'd0, 0, 1, 2'd3, 4'b1000, 3'd1, 3'b000);
    for (int i = 0; i < 15; i++)
      step(0, 2'd0, 0, 2'd0, 0, 1, 2'd3, 4'b1000, 3'd1, 3'b000);
    step(0, 2'd0, 1, 2'd3, 0, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    // Activity every 10 cycles keeps the grant alive
    step(1, 2'd1, 0, 2'd0, 0, 1, 2'd1, 4'b0010, 3'd1, 3'b000);
    for (int i = 1; i <= 40; i++)
      step(0, 2'd0, 0, 2'd0, (i % 10) == 0, 1, 2'd1, 4'b0010, 3'd1, 3'b000);
    step(0, 2'd0, 1, 2'd1, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    // Reset mid-operation clears everything asynchronously
    step(1, 2'd0, 0, 2'd0, 1, 1, 2'd0, 4'b0001, 3'd1, 3'b000);
    step(1, 2'd1, 0, 2'd0, 1, 1, 2'd0, 4'b0011, 3'd2, 3'b000);
    step(1, 2'd2, 0, 2'd0, 1, 1, 2'd0, 4'b0111, 3'd3, 3'b000);
    @(posedge clk);
    #2;
    push = 1'b0;
    arst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);
    step(1, 2'd2, 0, 2'd0, 1, 1, 2'd2, 4'b0100, 3'd1, 3'b000);
    step(0, 2'd0, 1, 2'd2, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);
    step(0, 2'd0, 0, 2'd0, 1, 0, 2'd0, 4'b0000, 3'd0, 3'b000);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", -1, 32'(expq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
